// File: rtl/racetrack_pkg.sv
// Shared types and constants for the racetrack memory datapath: LiM opcodes,
// controller states and the best-case access latencies.
package racetrack_pkg;

  typedef enum logic [2:0] {
    LIM_NONE = 3'b000,
    LIM_XOR  = 3'b001,
    LIM_AND  = 3'b010,
    LIM_OR   = 3'b011
  } lim_op_e;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    READ,
    WRITE,
    DONE
  } rt_state_e;

  // Cycles from the request strobe to r_valid_o with the port already aligned
  localparam int MIN_LOAD_LATENCY  = 4;
  localparam int MIN_STORE_LATENCY = 5;

  function automatic lim_op_e decode_op(input logic [2:0] funct);
    case (funct)
      3'b001:  return LIM_XOR;
      3'b010:  return LIM_AND;
      3'b011:  return LIM_OR;
      default: return LIM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lim_lane_alu.sv
// Bytewise logic-in-memory unit: per enabled lane applies XOR/AND/OR against the
// mask (or passes a value through); disabled lanes either keep the stored byte or read as zero.
module lim_lane_alu
  import racetrack_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] mask,
  input  logic [31:0] pass,
  input  logic [3:0]  be,
  input  lim_op_e     op,
  input  logic        keep,
  output logic [31:0] y
);

  function automatic logic [7:0] lane_op(input lim_op_e o, input logic [7:0] w,
                                         input logic [7:0] m, input logic [7:0] p);
    case (o)
      LIM_XOR: return w ^ m;
      LIM_AND: return w & m;
      LIM_OR:  return w | m;
      default: return p;
    endcase
  endfunction

  always_comb begin
    y = '0;
    for (int n = 0; n < 4; n++) begin
      if (be[n])
        y[8*n +: 8] = lane_op(op, word[8*n +: 8], mask[8*n +: 8], pass[8*n +: 8]);
      else
        y[8*n +: 8] = keep ? word[8*n +: 8] : 8'h00;
    end
  end

endmodule

// File: rtl/racetrack_mem_datapath.sv
// Word-organised racetrack memory with logic-in-memory loads/stores. One request
// at a time: align the access port by shifting, then wait for read/write current pulses.
module racetrack_mem_datapath
  import racetrack_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_SIZE   = 256
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_ab_i,
  input  logic [3:0]            be_b_i,
  input  logic                  Bz_s_i,
  input  logic                  read_pulse_i,
  input  logic                  write_pulse_i,
  input  logic [ADDR_WIDTH-1:0] ADDR_i,
  input  logic [31:0]           write_i_data_i,
  input  logic                  write_en_data_i,
  input  logic [31:0]           mask_i,
  input  logic [2:0]            logic_in_memory_funct_int_i,
  input  logic                  range_active_i,
  output logic [31:0]           r_data_o,
  output logic                  r_valid_o
);

  localparam int          WORDS   = MAX_SIZE / 4;
  localparam int unsigned WORDS_U = WORDS;
  localparam int          IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_WIDTH-3:0] w);
    int unsigned t;
    t = 32'(w) % WORDS_U;
    return IDX_W'(t);
  endfunction

  rt_state_e        state, nxt;
  logic [IDX_W-1:0] pos, tgt;
  logic [3:0]       req_be;
  logic             req_we;
  logic [31:0]      req_wdata, req_mask;
  lim_op_e          req_op;
  logic [31:0]      buf_w, alu_y;
  logic             rd_prev, wr_prev;
  logic             rd_rise, wr_rise;
  logic [31:0]      mem [WORDS];

  logic unused_ok;
  assign unused_ok = ^{range_active_i, ADDR_i[1:0]};

  assign rd_rise = read_pulse_i & ~rd_prev;
  assign wr_rise = write_pulse_i & ~wr_prev;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (en_ab_i)    nxt = SHIFT;
      SHIFT:   if (pos == tgt) nxt = READ;
      READ:    if (rd_rise)    nxt = req_we ? WRITE : DONE;
      WRITE:   if (wr_rise)    nxt = DONE;
      DONE:                    nxt = IDLE;
      default:                 nxt = IDLE;
    endcase
  end

  // Plain stores pass the new data; everything else passes the stored word
  lim_lane_alu u_alu (
    .word (buf_w),
    .mask (req_mask),
    .pass (req_we ? req_wdata : buf_w),
    .be   (req_be),
    .op   (req_op),
    .keep (req_we),
    .y    (alu_y)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      pos       <= '0;
      tgt       <= '0;
      req_be    <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      req_mask  <= '0;
      req_op    <= LIM_NONE;
      buf_w     <= '0;
      rd_prev   <= 1'b1;
      wr_prev   <= 1'b1;
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
    end else begin
      rd_prev   <= read_pulse_i;
      wr_prev   <= write_pulse_i;
      r_valid_o <= 1'b0;
      case (state)
        IDLE: if (en_ab_i) begin
          tgt       <= wrap_idx(ADDR_i[ADDR_WIDTH-1:2]);
          req_be    <= be_b_i;
          req_we    <= write_en_data_i;
          req_wdata <= write_i_data_i;
          req_mask  <= mask_i;
          req_op    <= decode_op(logic_in_memory_funct_int_i);
        end
        SHIFT: if (pos != tgt && Bz_s_i) begin
          pos <= (pos < tgt) ? pos + 1'b1 : pos - 1'b1;
        end
        READ:  if (rd_rise) buf_w <= mem[pos];
        WRITE: if (wr_rise) mem[pos] <= alu_y;
        DONE: begin
          r_data_o  <= alu_y;
          r_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_racetrack_mem_datapath.sv
// Directed bench for racetrack_mem_datapath: plain and LiM loads/stores, byte lanes,
// latency, strobe edge behaviour, busy-request rejection and mid-operation reset.
module tb_racetrack_mem_datapath;
  import racetrack_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en_ab;
  logic [3:0]  be_b;
  logic        bz;
  logic        rp, wp;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] mask;
  logic [2:0]  funct;
  logic        range_active;
  logic [31:0] r_data;
  logic        r_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  racetrack_mem_datapath #(.ADDR_WIDTH(8), .MAX_SIZE(256)) dut (
    .clk_i                       (clk),
    .rstn_i                      (rstn),
    .en_ab_i                     (en_ab),
    .be_b_i                      (be_b),
    .Bz_s_i                      (bz),
    .read_pulse_i                (rp),
    .write_pulse_i               (wp),
    .ADDR_i                      (addr),
    .write_i_data_i              (wdata),
    .write_en_data_i             (we),
    .mask_i                      (mask),
    .logic_in_memory_funct_int_i (funct),
    .range_active_i              (range_active),
    .r_data_o                    (r_data),
    .r_valid_o                   (r_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issues one request, free-runs the strobes, returns r_data_o at the valid pulse
  // and checks that exactly one pulse occurs. poke re-asserts en_ab while busy.
  task automatic req(input string tag, input logic [7:0] a, input logic [3:0] b,
                     input logic w, input logic [31:0] d, input logic [31:0] m,
                     input logic [2:0] f, input bit poke, output logic [31:0] data);
    int pulses, since;
    @(negedge clk);
    addr = a; be_b = b; we = w; wdata = d; mask = m; funct = f; en_ab = 1'b1;
    @(negedge clk);
    en_ab = 1'b0;
    pulses = 0; since = 0; data = '0;
    for (int c = 0; c < 300; c++) begin
      en_ab = poke && (c == 1);
      if (poke && c == 1) begin
        addr = 8'd12; wdata = 32'h0000_DEAD; we = 1'b1; funct = 3'b000;
      end
      rp = ~rp; wp = ~wp; bz = 1'b1;
      @(negedge clk);
      if (r_valid) begin
        pulses++;
        data = r_data;
      end
      if (pulses > 0) since++;
      if (since >= 3) break;
    end
    en_ab = 1'b0;
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
  endtask

  logic [31:0] d;
  logic [31:0] orig [5];
  logic [31:0] exp_or [5];
  logic [31:0] exp_and [5];
  int seen;

  initial begin
    orig    = '{32'h0, 32'h349B, 32'h6936, 32'h9DD1, 32'hD26C};
    exp_or  = '{32'hF1, 32'h34FB, 32'h69F7, 32'h9DF1, 32'hD2FD};
    exp_and = '{32'h81, 32'h89, 32'h85, 32'h81, 32'h8D};
    rstn = 1'b0; en_ab = 1'b0; be_b = 4'hF; bz = 1'b0; rp = 1'b0; wp = 1'b0;
    addr = '0; wdata = '0; we = 1'b0; mask = '0; funct = '0; range_active = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", r_data, 32'h0);
    check("rst_valid", {31'b0, r_valid}, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // Best-case load latency with port already at word 0
    addr = 8'd0; be_b = 4'hF; we = 1'b0; funct = 3'b000; bz = 1'b1; en_ab = 1'b1;
    @(negedge clk);
    en_ab = 1'b0;
    check("lat_e1", {31'b0, r_valid}, 32'h0);
    @(negedge clk);
    rp = 1'b1;
    check("lat_e2", {31'b0, r_valid}, 32'h0);
    @(negedge clk);
    check("lat_e3", {31'b0, r_valid}, 32'h0);
    @(negedge clk);
    check("lat_valid", {31'b0, r_valid}, 32'h1);
    check("lat_data", r_data, 32'h0);
    @(negedge clk);
    check("lat_one_pulse", {31'b0, r_valid}, 32'h0);

    // Read strobe held high must not complete a new load
    en_ab = 1'b1;
    @(negedge clk);
    en_ab = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    check("held_no_retrigger", 32'(seen), 32'd0);
    rp = 1'b0;
    @(negedge clk);
    rp = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    check("fresh_edge_completes", 32'(seen), 32'd1);

    for (int i = 0; i < 5; i++) begin
      req("st", 8'(4*i), 4'hF, 1'b1, orig[i], 32'h0, 3'b000, 1'b0, d);
      check($sformatf("st_rdata%0d", i), d, orig[i]);
    end
    for (int i = 0; i < 5; i++) begin
      req("ld", 8'(4*i), 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
      check($sformatf("ld_plain%0d", i), d, orig[i]);
    end
    for (int i = 0; i < 5; i++)
      req("or_st", 8'(4*i), 4'hF, 1'b1, 32'hFFFF_FFFF, 32'hF1, 3'b011, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      req("ld", 8'(4*i), 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
      check($sformatf("ld_or%0d", i), d, exp_or[i]);
    end
    for (int i = 0; i < 5; i++)
      req("and_st", 8'(4*i), 4'hF, 1'b1, 32'hFFFF_FFFF, 32'h8D, 3'b010, 1'b0, d);
    for (int i = 0; i < 5; i++) begin
      req("ld", 8'(4*i), 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
      check($sformatf("ld_and%0d", i), d, exp_and[i]);
    end
    for (int i = 0; i < 5; i++)
      req("restore", 8'(4*i), 4'hF, 1'b1, orig[i], 32'h0, 3'b000, 1'b0, d);

    req("and_ld", 8'd4, 4'hF, 1'b0, 32'h0, 32'hF1, 3'b010, 1'b0, d);
    check("and_ld_f1", d, 32'h91);
    req("ld", 8'd4, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("and_ld_mem_kept", d, 32'h349B);
    req("xor_ld", 8'd8, 4'hF, 1'b0, 32'h0, 32'h0000_FFFF, 3'b001, 1'b0, d);
    check("xor_ld", d, 32'h96C9);
    req("bad_op_ld", 8'd8, 4'hF, 1'b0, 32'h0, 32'h0000_FFFF, 3'b111, 1'b0, d);
    check("bad_op_is_none", d, 32'h6936);

    req("be1", 8'd4, 4'b0001, 1'b0, 32'h0, 32'h8D, 3'b010, 1'b0, d);
    check("be0001", d, 32'h89);
    req("be3", 8'd4, 4'b0011, 1'b0, 32'h0, 32'h8D, 3'b010, 1'b0, d);
    check("be0011", d, 32'h89);
    req("beF", 8'd4, 4'b1111, 1'b0, 32'h0, 32'h8D, 3'b010, 1'b0, d);
    check("be1111", d, 32'h89);

    req("lane_st", 8'd4, 4'b0010, 1'b1, 32'hDEAD_BEEF, 32'h8D, 3'b010, 1'b0, d);
    check("lane_st_rdata", d, 32'h9B);
    req("ld", 8'd4, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("lane_st_mem", d, 32'h9B);

    // Top word, low address bits ignored; a busy-time request must be dropped
    req("top_st", 8'hFC, 4'hF, 1'b1, 32'hA5A5_5A5A, 32'h0, 3'b000, 1'b1, d);
    req("ld", 8'hFF, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("top_word", d, 32'hA5A5_5A5A);
    req("ld", 8'd12, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("busy_en_ignored", d, 32'h9DD1);

    // Abort a store while the port is still shifting
    @(negedge clk);
    addr = 8'd200; be_b = 4'hF; we = 1'b1; wdata = 32'hFFFF_FFFF; funct = 3'b000;
    bz = 1'b1; en_ab = 1'b1;
    @(negedge clk);
    en_ab = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    #2 rstn = 1'b0;
    #1;
    check("abort_data", r_data, 32'h0);
    repeat (2) begin
      @(negedge clk);
      if (r_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    rstn = 1'b1;
    req("ld", 8'd200, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("abort_no_write", d, 32'h0);
    req("ld", 8'd4, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("rst_mem4", d, 32'h0);
    req("ld", 8'd12, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("rst_mem12", d, 32'h0);
    req("ld", 8'hFC, 4'hF, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, d);
    check("rst_mem_top", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/racetrack_mem_datapath.md
Name: racetrack_mem_datapath

Overview:
Word-organised racetrack memory datapath with Logic-in-Memory (LiM) support. It stores MAX_SIZE bytes and serves one request at a time. Each request is a plain or LiM load/store, and completes with a one-cycle r_valid_o pulse. Timing follows a racetrack model: the access port shifts one word position per shift strobe, then waits for the read and/or write current pulse strobes. It sits between the core's memory interface and the racetrack storage model.

Parameters:
ADDR_WIDTH, 8, byte address width.
MAX_SIZE, 256, capacity in bytes; must be a multiple of 4. Number of words is MAX_SIZE/4.

Ports:
clk_i  in  1  system clock; the only clock.
rstn_i  in  1  reset, asynchronous, active-low.
en_ab_i  in  1  request strobe; accepted only in IDLE.
be_b_i  in  4  byte-lane enables; bit n selects byte n.
Bz_s_i  in  1  shift strobe, sampled on clk_i.
read_pulse_i  in  1  read-current strobe, sampled on clk_i.
write_pulse_i  in  1  write-current strobe, sampled on clk_i.
ADDR_i  in  ADDR_WIDTH  byte address; word index is ADDR_i[ADDR_WIDTH-1:2].
write_i_data_i  in  32  store data, used by plain stores only.
write_en_data_i  in  1  1 = store, 0 = load.
mask_i  in  32  LiM operand.
logic_in_memory_funct_int_i  in  3  000 none, 001 XOR, 010 AND, 011 OR, others treated as none.
range_active_i  in  1  reserved; ignored.
r_data_o  out  32  result word.
r_valid_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous): all memory words to 0, port position to 0, FSM to IDLE, r_data_o = 0, r_valid_o = 0.
- Request capture: in IDLE, en_ab_i = 1 at a clk_i edge latches ADDR_i, be_b_i, write_en_data_i, write_i_data_i, mask_i and the opcode, then goes to SHIFT. en_ab_i is ignored in every other state.
- Addressing: ADDR_i[1:0] is ignored. A word index of MAX_SIZE/4 or above wraps modulo MAX_SIZE/4.
- SHIFT: while position != target, each cycle with Bz_s_i = 1 moves position one step toward target. When equal, go to READ. Position persists between requests.
- READ: wait for a rising edge of read_pulse_i (sampled value 0 then 1). On that edge, load the stored word into a buffer W.
  - Load: go to DONE.
  - Store: go to WRITE.
- WRITE: wait for a rising edge of write_pulse_i, then commit and go to DONE.
- Lane rules (per byte lane n):
  - Store, opcode none: new_n = be[n] ? write_data_n : W_n.
  - Store, LiM: new_n = be[n] ? (W_n OP mask_n) : W_n. write_i_data_i is ignored.
  - Load, opcode none: out_n = be[n] ? W_n : 0.
  - Load, LiM: out_n = be[n] ? (W_n OP mask_n) : 0. Memory is left unchanged.
  - The mask is applied lane-aligned, with no shifting.
- DONE: r_valid_o = 1 for exactly one cycle, then back to IDLE.
  - r_data_o = out (load) or the new stored word (store); it holds until the next DONE.
- Minimum latency, with position already at target and strobes present: 4 cycles from en_ab_i to r_valid_o.
- Strobe levels held high do not retrigger; each access needs a fresh rising edge.
- Reset asserted mid-operation aborts the request with no partial write, and r_valid_o is not pulsed.

Decomposition:
- Package racetrack_pkg holds:
  - the opcode enum: LIM_NONE = 3'b000, LIM_XOR = 3'b001, LIM_AND = 3'b010, LIM_OR = 3'b011;
  - the FSM state enum: IDLE, SHIFT, READ, WRITE, DONE;
  - the timing constants used by benches.
- One sub-module, lim_lane_alu: a combinational 32-bit bytewise XOR/AND/OR/pass unit with per-lane enable and zero/keep selection for disabled lanes.

Test Plan:
- Plain stores of 0x0, 0x349B, 0x6936, 0x9DD1, 0xD26C at addresses 0, 4, 8, 12, 16 (be = 1111), then reads -> the same values returned, one r_valid_o pulse per request.
- LiM OR store with mask 0xF1 on those words, then reads -> 0x000000F1, 0x000034FB, 0x000069F7, 0x00009DF1, 0x0000D2FD.
- LiM AND store with mask 0x8D on the OR results, then reads -> 0x81, 0x89, 0x85, 0x81, 0x8D.
- Restore the original data, then LiM AND load at address 4 with mask 0xF1 -> r_data_o = 0x00000091. A following plain read of address 4 returns 0x0000349B.
- Byte-lane loads at address 4 with AND and mask 0x8D:
  - be = 0001 -> 0x00000089;
  - be = 0011 -> 0x00000089;
  - be = 1111 -> 0x00000089.
- Byte-lane LiM AND store at address 4 with mask 0x8D and be = 0010, using a stale write_i_data_i value, then a plain read -> 0x0000009B. Also pulse en_ab_i while busy and assert reset mid-SHIFT -> the extra en_ab_i is ignored, and after reset all outputs and memory are 0.
